// File: rtl/vc_test_mem_pkg.sv
// vc_test_mem_pkg: message layout, type encodings and byte-lane helpers shared by the test memory responder.
package vc_test_mem_pkg;
    localparam int REQ_W  = 67;
    localparam int RESP_W = 35;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 2;

    typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;

    typedef struct packed {
        mem_type_e           typ;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
    } mem_req_t;

    typedef struct packed {
        mem_type_e           typ;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
    } mem_resp_t;

    function automatic logic [2:0] len_nbytes(input logic [LEN_W-1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

    // Lanes past 3 fall off the top, so boundary-crossing accesses never wrap into the next word.
    function automatic logic [3:0] byte_mask(input logic [1:0] lane, input logic [LEN_W-1:0] len);
        logic [7:0] w;
        w = (8'h01 << len_nbytes(len)) - 8'h01;
        w = w << lane;
        return w[3:0];
    endfunction
endpackage

// File: rtl/vc_mem_resp_delay_pipe.sv
// vc_mem_resp_delay_pipe: LATENCY-deep shift register of {valid, response}, synchronously cleared on reset.
module vc_mem_resp_delay_pipe
    import vc_test_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_val,
    input  logic [RESP_W-1:0] i_msg,
    output logic              o_val,
    output logic [RESP_W-1:0] o_msg
);
    logic [LATENCY-1:0] r_val;
    logic [RESP_W-1:0]  r_msg [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_val <= '0;
            for (int k = 0; k < LATENCY; k++) r_msg[k] <= '0;
        end else begin
            r_val[0] <= i_val;
            r_msg[0] <= i_val ? i_msg : '0;
            for (int k = 1; k < LATENCY; k++) begin
                r_val[k] <= r_val[k-1];
                r_msg[k] <= r_msg[k-1];
            end
        end
    end

    assign o_val = r_val[LATENCY-1];
    assign o_msg = r_msg[LATENCY-1];
endmodule

// File: rtl/vc_test_mem_responder.sv
// vc_test_mem_responder: single-port fixed-latency memory target for vc_MemReqMsg/vc_MemRespMsg with host preload.
// Define VC_TEST_MEM_RANDOM_STALL_EN to add LFSR-driven request stalls.
module vc_test_mem_responder
    import vc_test_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  memreq_msg,
    input  logic              memreq_val,
    output logic              memreq_rdy,
    output logic [RESP_W-1:0] memresp_msg,
    output logic              memresp_val,
    input  logic              load_en,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data
);
    localparam int IW = $clog2(MEM_WORDS);

    logic [31:0]       r_mem [MEM_WORDS];
    mem_req_t          w_req;
    mem_resp_t         w_resp;
    logic [IW-1:0]     w_idx;
    logic [4:0]        w_sh;
    logic [3:0]        w_be;
    logic [31:0]       w_word;
    logic [31:0]       w_bmask;
    logic [31:0]       w_rdata;
    logic              w_acc;
    logic              w_pv;
    logic [RESP_W-1:0] w_pm;
    logic              w_unused;

    assign w_req   = memreq_msg;
    assign w_idx   = w_req.addr[IW+1:2];
    assign w_sh    = {w_req.addr[1:0], 3'b000};
    assign w_be    = byte_mask(w_req.addr[1:0], w_req.len);
    assign w_bmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_word  = r_mem[w_idx];
    assign w_rdata = (w_word & w_bmask) >> w_sh;
    assign w_acc   = memreq_val && memreq_rdy;

    assign w_resp.typ  = w_req.typ;
    assign w_resp.len  = w_req.len;
    assign w_resp.data = (w_req.typ == MEM_WRITE) ? 32'h0 : w_rdata;

    // Reads use the combinational pre-edge word, so a write on the same edge is not seen.
    always_ff @(posedge clk) begin
        if (load_en)
            r_mem[load_addr[IW+1:2]] <= load_data;
        else if (w_acc && w_req.typ == MEM_WRITE)
            r_mem[w_idx] <= (w_word & ~w_bmask) | ((w_req.data << w_sh) & w_bmask);
    end

`ifdef VC_TEST_MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign memreq_rdy = !reset && !load_en && (r_lfsr[1:0] != 2'b00);
`else
    assign memreq_rdy = !reset && !load_en;
`endif

    vc_mem_resp_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk   (clk),
        .reset (reset),
        .i_val (w_acc),
        .i_msg (w_resp),
        .o_val (w_pv),
        .o_msg (w_pm)
    );

    // Gating with reset keeps the outputs quiet during the reset cycle itself.
    assign memresp_val = !reset && w_pv;
    assign memresp_msg = reset ? '0 : w_pm;

    assign w_unused = ^{load_addr[31:IW+2], load_addr[1:0], w_req.addr[31:IW+2], LFSR_SEED};
endmodule

// File: tb/tb_vc_test_mem_responder.sv
// tb_vc_test_mem_responder: directed vector table, hand sequences and a randomized byte-level reference model.
module tb_vc_test_mem_responder;
    localparam int LAT = 3;

    logic        clk = 0;
    logic        reset = 1;
    logic [66:0] memreq_msg = '0;
    logic        memreq_val = 0;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;
    logic        load_en = 0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    vc_test_mem_responder #(.MEM_WORDS(4096), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [34:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [34:0] msg;
    } exp_t;

    exp_t       q[$];
    vec_t       tbl[15];
    logic [7:0] mb[64];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    task automatic check_resp();
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("resp_val", 64'(memresp_val), 64'd1);
            chk("resp_msg", 64'(memresp_msg), 64'(q[0].msg));
            void'(q.pop_front());
        end else
            chk("idle_val", 64'(memresp_val), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_resp();
    endtask

    task automatic issue(input logic ty, input logic [31:0] a, input logic [1:0] ln, input logic [31:0] d,
                         input logic [34:0] exp);
        int g = 0;
        memreq_msg = {ty, a, ln, d};
        memreq_val = 1;
        #1;
        while (!memreq_rdy && g < 64) begin
            step();
            g++;
        end
        if (!memreq_rdy) chk("rdy_timeout", 64'(memreq_rdy), 64'd1);
        q.push_back('{cyc + LAT, exp});
        step();
        memreq_val = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1;
        load_addr = a;
        load_data = d;
        #1;
        chk("load_blocks_rdy", 64'(memreq_rdy), 64'd0);
        step();
        load_en = 0;
    endtask

    // Byte-addressed model of the 16-word region used by the random phase.
    function automatic logic [31:0] mread(input logic [31:0] a, input logic [1:0] ln);
        int n = (ln == 2'd0) ? 4 : int'(ln);
        int lane = int'(a[1:0]);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++)
            if (lane + i < 4) r[8*i +: 8] = mb[int'(a[5:2]) * 4 + lane + i];
        return r;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [1:0] ln, input logic [31:0] d);
        int n = (ln == 2'd0) ? 4 : int'(ln);
        int lane = int'(a[1:0]);
        for (int i = 0; i < n; i++)
            if (lane + i < 4) mb[int'(a[5:2]) * 4 + lane + i] = d[8*i +: 8];
    endtask

    task automatic mload(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) mb[int'(a[5:2]) * 4 + i] = d[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  ln;
        logic        ty;
        int          acc = 0;
        int          n_free = 0;
        int          n_stall = 0;

        tbl[0]  = '{1'b0, 32'h0000_0100, 2'd0, 32'h0,         {1'b0, 2'd0, 32'hDEADBEEF}};
        tbl[1]  = '{1'b0, 32'h0000_0103, 2'd1, 32'h0,         {1'b0, 2'd1, 32'h000000DE}};
        tbl[2]  = '{1'b0, 32'h0000_0102, 2'd2, 32'h0,         {1'b0, 2'd2, 32'h0000DEAD}};
        tbl[3]  = '{1'b0, 32'h0000_4100, 2'd0, 32'h0,         {1'b0, 2'd0, 32'hDEADBEEF}};
        tbl[4]  = '{1'b0, 32'h0000_0101, 2'd3, 32'h0,         {1'b0, 2'd3, 32'h00DEADBE}};
        tbl[5]  = '{1'b0, 32'h0000_0103, 2'd2, 32'h0,         {1'b0, 2'd2, 32'h000000DE}};
        tbl[6]  = '{1'b1, 32'h0000_0101, 2'd1, 32'hAAAAAA55,  {1'b1, 2'd1, 32'h0}};
        tbl[7]  = '{1'b0, 32'h0000_0100, 2'd0, 32'h0,         {1'b0, 2'd0, 32'hDEAD55EF}};
        tbl[8]  = '{1'b1, 32'h0000_0103, 2'd2, 32'h00001234,  {1'b1, 2'd2, 32'h0}};
        tbl[9]  = '{1'b0, 32'h0000_0100, 2'd0, 32'h0,         {1'b0, 2'd0, 32'h34AD55EF}};
        tbl[10] = '{1'b1, 32'h0000_0200, 2'd0, 32'h01020304,  {1'b1, 2'd0, 32'h0}};
        tbl[11] = '{1'b0, 32'h0000_0201, 2'd3, 32'h0,         {1'b0, 2'd3, 32'h00010203}};
        tbl[12] = '{1'b0, 32'h0000_0202, 2'd1, 32'h0,         {1'b0, 2'd1, 32'h00000002}};
        tbl[13] = '{1'b1, 32'hFFFF_C202, 2'd2, 32'h0000BEEF,  {1'b1, 2'd2, 32'h0}};
        tbl[14] = '{1'b0, 32'h0000_0200, 2'd0, 32'h0,         {1'b0, 2'd0, 32'hBEEF0304}};

        #1;
        chk("reset_rdy", 64'(memreq_rdy), 64'd0);
        repeat (3) step();
        chk("reset_rdy_held", 64'(memreq_rdy), 64'd0);
        chk("reset_msg", 64'(memresp_msg), 64'd0);
        reset = 0;
        #1;
        chk("rdy_after_reset", 64'(memreq_rdy), 64'd1);

        load(32'h100, 32'hDEADBEEF);
        for (int i = 0; i < 15; i++) issue(tbl[i].typ, tbl[i].addr, tbl[i].len, tbl[i].data, tbl[i].exp);
        repeat (LAT + 1) step();

        load(32'h0, 32'h11111111);
        load(32'h4, 32'h22222222);
        load(32'h8, 32'h33333333);
        issue(1'b0, 32'h0, 2'd0, 32'h0, {1'b0, 2'd0, 32'h11111111});
        issue(1'b0, 32'h4, 2'd0, 32'h0, {1'b0, 2'd0, 32'h22222222});
        issue(1'b0, 32'h8, 2'd0, 32'h0, {1'b0, 2'd0, 32'h33333333});
        repeat (LAT + 1) step();

        issue(1'b0, 32'h100, 2'd0, 32'h0, {1'b0, 2'd0, 32'hBADBAD00});
        reset = 1;
        q.delete();
        #1;
        chk("midreset_rdy", 64'(memreq_rdy), 64'd0);
        chk("midreset_val", 64'(memresp_val), 64'd0);
        step();
        chk("midreset_msg", 64'(memresp_msg), 64'd0);
        reset = 0;
        #1;
        chk("rdy_after_midreset", 64'(memreq_rdy), 64'd1);
        repeat (LAT + 2) step();

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            load(32'(i * 4), d);
            mload(32'(i * 4), d);
        end

        for (int c = 0; c < 8000 && acc < 1000; c++) begin
            load_en = ($urandom_range(0, 9) == 0);
            load_addr = $urandom & 32'hFFFF_C03F;
            load_data = $urandom;
            ty = 1'($urandom_range(0, 1));
            a = $urandom & 32'hFFFF_C03F;
            ln = 2'($urandom_range(0, 3));
            d = $urandom;
            memreq_val = ($urandom_range(0, 3) != 0);
            memreq_msg = {ty, a, ln, d};
            #1;
            if (!load_en) begin
                n_free++;
                if (!memreq_rdy) n_stall++;
            end
`ifndef VC_TEST_MEM_RANDOM_STALL_EN
            chk("rdy_rule", 64'(memreq_rdy), 64'(!load_en));
`endif
            if (load_en) mload(load_addr, load_data);
            else if (memreq_val && memreq_rdy) begin
                q.push_back('{cyc + LAT, {ty, ln, ty ? 32'h0 : mread(a, ln)}});
                if (ty) mwrite(a, ln, d);
                acc++;
            end
            step();
        end
        memreq_val = 0;
        load_en = 0;
        chk("rand_accepted", 64'(acc), 64'd1000);
        repeat (LAT + 2) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
`ifdef VC_TEST_MEM_RANDOM_STALL_EN
        chk("stall_rate", 64'(n_stall * 100 >= n_free * 20 && n_stall * 100 <= n_free * 30), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vc_test_mem_responder.md
Name: vc_test_mem_responder

Overview:
- Single-port memory responder: the target end of the vc_MemReqMsg/vc_MemRespMsg protocol that the core's imem and dmem ports initiate.
- Accepts 67-bit requests on a val/rdy handshake, performs word or sub-word reads and writes on an internal array, and returns 35-bit responses after a fixed latency.
- Responses are val-only; the core always accepts them.
- Used in the core test harness, one instance per memory port.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words; must be a power of 2; index = addr[log2(MEM_WORDS)+1:2].
- LATENCY, 2, cycles from request acceptance to memresp_val; legal range 1..8.
- LFSR_SEED, 16'hACE1, nonzero seed for the stall LFSR; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- memreq_msg  in  67  [66] type (0 = read, 1 = write), [65:34] addr, [33:32] len, [31:0] data
- memreq_val  in  1  request valid
- memreq_rdy  out  1  request ready
- memresp_msg  out  35  [34] type, [33:32] len, [31:0] data
- memresp_val  out  1  response valid; no back-pressure
- load_en  in  1  host preload write enable
- load_addr  in  32  byte address of the preload word (bits [1:0] ignored)
- load_data  in  32  preload word

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset:
  - All pipeline valid bits clear; memresp_val = 0; memresp_msg = 0; memreq_rdy = 0 during the reset cycle.
  - Array contents are not cleared by reset.
- memreq_rdy = !reset && !load_en (without the optional feature).
- A request is accepted when memreq_val && memreq_rdy on a rising edge.
- len encoding: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = 3 bytes. Byte lane = addr[1:0]; little-endian.
- Write, on acceptance:
  - Updates bytes [addr[1:0] .. addr[1:0]+nbytes-1] of the word with the low nbytes of data.
  - The array update is visible to a read accepted on the next cycle.
- Read, on acceptance:
  - Samples the word as it exists before any write in the same edge.
  - Shifts the selected bytes down to bit 0 and zero-extends them. Sign extension is the core's responsibility.
- Response:
  - type and len echo the request.
  - data = read data for reads, 32'h0 for writes.
- Latency: a request accepted at edge N produces memresp_val = 1 during the cycle after edge N+LATENCY-1. LATENCY = 1 means valid in the cycle immediately following acceptance.
- Throughput: one request per cycle; responses are returned in order.
- Sub-word access crossing a word boundary (addr[1:0] + nbytes > 4): bytes beyond lane 3 are dropped on writes and read as 0 on reads. No wrap into the next word.
- Addresses beyond the array wrap modulo MEM_WORDS*4; upper address bits are ignored.
- Preload port:
  - load_en writes the full word on the same edge.
  - It blocks requests that cycle through memreq_rdy = 0.
  - In-flight responses are unaffected.
- Reset asserted mid-operation: all in-flight responses are discarded. No memresp_val occurs in the cycle after the reset edge, nor for any request accepted before it.

Optional Feature:
- Macro: VC_TEST_MEM_RANDOM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) loads LFSR_SEED on reset and advances every non-reset cycle.
  - memreq_rdy is additionally forced to 0 when lfsr[1:0] == 2'b00 (about 25% stall rate), to exercise core stall paths.
- When undefined: no LFSR; memreq_rdy follows the base rule.

Decomposition:
- Shared package vc_test_mem_pkg:
  - request/response field offsets and widths;
  - type encodings READ/WRITE;
  - len-to-byte-count function;
  - byte-enable mask generation function.
- Sub-module vc_mem_resp_delay_pipe:
  - parameterised LATENCY-deep shift register of {valid, 35-bit resp};
  - synchronous clear on reset.
- The top level holds the array, the lane logic, the handshake and the optional LFSR.

Test Plan:
- Preload word 0x100 = 32'hDEADBEEF; read, addr 0x100, len 0 -> after LATENCY cycles memresp_val = 1, msg = {0, 2'd0, 32'hDEADBEEF}.
- Byte read, addr 0x103, len 1, on the same word -> data 32'h000000DE. Halfword read, addr 0x102, len 2 -> 32'h0000DEAD.
- Byte write of 0x55 at addr 0x101, then a read of 0x100 on the next cycle:
  - write response is {1, 2'd1, 32'h0};
  - read returns 32'hDEAD55EF.
- Back-to-back reads of 0x0, 0x4, 0x8 on consecutive cycles, LATENCY = 3 -> three consecutive memresp_val cycles, in order, starting 3 cycles after the first acceptance.
- Reset asserted one cycle after a read is accepted -> memresp_val stays 0 throughout. memreq_rdy = 0 during reset and 1 on the following cycle.
- With VC_TEST_MEM_RANDOM_STALL_EN, run 1000 random requests against a reference model:
  - every accepted request gets exactly one response with matching data;
  - memreq_rdy is low on roughly 20–30% of cycles.
